// File: rtl/mask_gather_if.sv
// Bundle of the mask_gather row-input, packed-output and handshake signals.
// slave is the gather block itself; master is the producer/consumer side.
interface mask_gather_if #(
  parameter int unsigned IL     = 4,
  parameter int unsigned FL     = 16,
  parameter int unsigned length = 32
);
  localparam int unsigned W = IL + FL;

  logic [length-1:0]   i_mask;
  logic                mask_valid;
  logic signed [W-1:0] i_data;
  logic                i_valid;
  logic                i_ready;
  logic signed [W-1:0] out [16];
  logic [length-1:0]   o_mask;
  logic [4:0]          count;
  logic                overflow;
  logic                o_valid;
  logic                output_taken;
  logic [1:0]          state;

  modport master (
    output i_mask, mask_valid, i_data, i_valid, output_taken,
    input  i_ready, out, o_mask, count, overflow, o_valid, state
  );

  modport slave (
    input  i_mask, mask_valid, i_data, i_valid, output_taken,
    output i_ready, out, o_mask, count, overflow, o_valid, state
  );
endinterface

// File: rtl/mask_gather.sv
// Gathers the mask-selected elements of a dense row into a 16-entry packed buffer.
// Optional GATHER_ZERO_SKIP_EN: selected zero elements are not packed.
module mask_gather #(
  parameter int unsigned IL     = 4,
  parameter int unsigned FL     = 16,
  parameter int unsigned length = 32
) (
  input logic           clk,
  input logic           reset,
  mask_gather_if.slave  bus
);
  localparam int unsigned W        = IL + FL;
  localparam int unsigned p_length = $clog2(length);
  localparam logic [p_length-1:0] LastIdx = p_length'(length - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGather = 2'b01,
    StHold   = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [length-1:0]   mask_q, mask_d;
  logic [p_length-1:0] e_ptr_q, e_ptr_d;
  logic signed [W-1:0] out_q [16];
  logic signed [W-1:0] out_d [16];
  logic [length-1:0]   o_mask_q, o_mask_d;
  logic [4:0]          count_q, count_d;
  logic                overflow_q, overflow_d;

  logic is_zero;
  logic sel;
  logic full;

`ifdef GATHER_ZERO_SKIP_EN
  assign is_zero = (bus.i_data == '0);
`else
  assign is_zero = 1'b0;
`endif

  // Zeros are excluded before the capacity test, so they can never raise overflow.
  assign sel  = mask_q[e_ptr_q] & ~is_zero;
  assign full = count_q[4];

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    e_ptr_d    = e_ptr_q;
    out_d      = out_q;
    o_mask_d   = o_mask_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (bus.mask_valid) begin
          mask_d     = bus.i_mask;
          e_ptr_d    = '0;
          o_mask_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          for (int k = 0; k < 16; k++) out_d[k] = '0;
          state_d    = StGather;
        end
      end
      StGather: begin
        if (bus.i_valid) begin
          if (sel && !full) begin
            out_d[count_q[3:0]] = bus.i_data;
            o_mask_d[e_ptr_q]   = 1'b1;
            count_d             = count_q + 5'd1;
          end else if (sel) begin
            overflow_d = 1'b1;
          end
          e_ptr_d = e_ptr_q + 1'b1;
          if (e_ptr_q == LastIdx) state_d = StHold;
        end
      end
      StHold: begin
        // A mask presented alongside output_taken is dropped on purpose.
        if (bus.output_taken) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      e_ptr_q    <= '0;
      o_mask_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < 16; k++) out_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      e_ptr_q    <= e_ptr_d;
      o_mask_q   <= o_mask_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < 16; k++) out_q[k] <= out_d[k];
    end
  end

  assign bus.i_ready  = (state_q == StGather);
  assign bus.o_valid  = (state_q == StHold);
  assign bus.state    = state_q;
  assign bus.o_mask   = o_mask_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.out      = out_q;

  // Packed bits must track the entry count and never leave the latched mask.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($countones(o_mask_q) == 32'(count_q));
      assert ((o_mask_q & ~mask_q) == '0);
    end
  end
endmodule

// File: tb/tb_mask_gather.sv
// Randomised and directed bench for mask_gather against a queue-based row model.
module tb_mask_gather;
  localparam int IL  = 4;
  localparam int FL  = 16;
  localparam int Len = 32;
  localparam int W   = IL + FL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mask_gather_if #(.IL(IL), .FL(FL), .length(Len)) bus ();

  mask_gather #(.IL(IL), .FL(FL), .length(Len)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int num_checks = 0;
  int num_errors = 0;

  logic [W-1:0]   row_data [Len];
  logic [W-1:0]   exp_out [16];
  logic [Len-1:0] exp_omask;
  int             exp_count;
  logic           exp_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Selected indices in order; the first 16 are packed, any beyond that mean overflow.
  task automatic model_row(input logic [Len-1:0] mask);
    int picks[$];
    picks = {};
    for (int e = 0; e < Len; e++) begin
`ifdef GATHER_ZERO_SKIP_EN
      if (mask[e] && row_data[e] != '0) picks.push_back(e);
`else
      if (mask[e]) picks.push_back(e);
`endif
    end
    exp_count = (picks.size() > 16) ? 16 : picks.size();
    exp_ovf   = (picks.size() > 16);
    exp_omask = '0;
    for (int k = 0; k < 16; k++) begin
      exp_out[k] = '0;
      if (k < exp_count) begin
        exp_out[k]           = row_data[picks[k]];
        exp_omask[picks[k]]  = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 16; k++)
      check_eq($sformatf("%s out[%0d]", tag, k), {44'b0, $unsigned(bus.out[k])},
               {44'b0, exp_out[k]});
    check_eq({tag, " o_mask"}, 64'(bus.o_mask), 64'(exp_omask));
    check_eq({tag, " count"}, 64'(bus.count), 64'(exp_count));
    check_eq({tag, " overflow"}, 64'(bus.overflow), 64'(exp_ovf));
  endtask

  // bubble_mode: 0 none, 1 alternate cycles, 2 random.
  task automatic run_row(input logic [Len-1:0] mask, input int bubble_mode,
                         input bit take_with_mask, input string tag);
    int n_hold;
    model_row(mask);
    check_eq({tag, " idle state"}, 64'(bus.state), 64'd0);
    bus.i_mask     = mask;
    bus.mask_valid = 1'b1;
    step();
    bus.mask_valid = 1'b0;
    bus.i_mask     = $urandom;
    check_eq({tag, " gather state"}, 64'(bus.state), 64'd1);
    check_eq({tag, " i_ready"}, 64'(bus.i_ready), 64'd1);
    check_eq({tag, " cleared count"}, 64'(bus.count), 64'd0);
    for (int e = 0; e < Len; e++) begin
      if (bubble_mode == 1 || (bubble_mode == 2 && $urandom_range(3) == 0)) begin
        bus.i_valid = 1'b0;
        bus.i_data  = W'($urandom);
        step();
        check_eq($sformatf("%s stall state e=%0d", tag, e), 64'(bus.state), 64'd1);
      end
      bus.i_valid = 1'b1;
      bus.i_data  = row_data[e];
      step();
      if (e < Len - 1)
        check_eq($sformatf("%s early o_valid e=%0d", tag, e), 64'(bus.o_valid), 64'd0);
    end
    bus.i_valid = 1'b0;
    check_eq({tag, " o_valid"}, 64'(bus.o_valid), 64'd1);
    check_eq({tag, " hold state"}, 64'(bus.state), 64'd2);
    check_eq({tag, " hold i_ready"}, 64'(bus.i_ready), 64'd0);
    check_outputs(tag);
    n_hold = $urandom_range(0, 2);
    for (int h = 0; h < n_hold; h++) begin
      bus.mask_valid = 1'b1;
      bus.i_valid    = 1'b1;
      bus.i_data     = W'($urandom);
      step();
      check_eq({tag, " hold stays"}, 64'(bus.state), 64'd2);
      check_eq({tag, " hold count stable"}, 64'(bus.count), 64'(exp_count));
    end
    bus.i_valid      = 1'b0;
    bus.mask_valid   = take_with_mask;
    bus.output_taken = 1'b1;
    step();
    bus.output_taken = 1'b0;
    bus.mask_valid   = 1'b0;
    check_eq({tag, " taken state"}, 64'(bus.state), 64'd0);
    check_eq({tag, " taken o_valid"}, 64'(bus.o_valid), 64'd0);
    check_eq({tag, " kept o_mask"}, 64'(bus.o_mask), 64'(exp_omask));
    step();
    check_eq({tag, " idle after take"}, 64'(bus.state), 64'd0);
  endtask

  initial begin
    logic [Len-1:0] m;
    logic [W-1:0]   outs_or;
    reset            = 1'b1;
    bus.i_mask       = '0;
    bus.mask_valid   = 1'b0;
    bus.i_data       = '0;
    bus.i_valid      = 1'b0;
    bus.output_taken = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("reset state", 64'(bus.state), 64'd0);
    check_eq("reset o_valid", 64'(bus.o_valid), 64'd0);
    check_eq("reset i_ready", 64'(bus.i_ready), 64'd0);
    check_eq("reset count", 64'(bus.count), 64'd0);
    check_eq("reset o_mask", 64'(bus.o_mask), 64'd0);
    check_eq("reset overflow", 64'(bus.overflow), 64'd0);

    for (int e = 0; e < Len; e++) row_data[e] = W'((e + 1) << 16);
    run_row(32'h0000000F, 0, 1'b0, "t1 low4");
    run_row(32'hFFFFFFFF, 0, 1'b1, "t2 full");
    run_row(32'h00000000, 0, 1'b0, "t3 empty");
    run_row(32'hAAAAAAAA, 1, 1'b0, "t4 alt");
    row_data[2] = '0;
    run_row(32'h000000FF, 0, 1'b0, "t6 zero");

    // Reset in the middle of a row must abort it completely.
    for (int e = 0; e < Len; e++) row_data[e] = W'((e + 1) << 16);
    bus.i_mask     = 32'hFFFFFFFF;
    bus.mask_valid = 1'b1;
    step();
    bus.mask_valid = 1'b0;
    for (int e = 0; e < 10; e++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = row_data[e];
      step();
    end
    bus.i_valid = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    outs_or = '0;
    for (int k = 0; k < 16; k++) outs_or = outs_or | bus.out[k];
    check_eq("t5 reset state", 64'(bus.state), 64'd0);
    check_eq("t5 reset o_valid", 64'(bus.o_valid), 64'd0);
    check_eq("t5 reset count", 64'(bus.count), 64'd0);
    check_eq("t5 reset o_mask", 64'(bus.o_mask), 64'd0);
    check_eq("t5 reset out", 64'(outs_or), 64'd0);
    run_row(32'h0F0F0F0F, 0, 1'b0, "t5 fresh");

    for (int r = 0; r < 20; r++) begin
      for (int e = 0; e < Len; e++)
        row_data[e] = ($urandom_range(3) == 0) ? '0 : W'($urandom);
      unique case (r % 4)
        0: m = $urandom;
        1: m = $urandom & $urandom & $urandom;
        2: m = $urandom | $urandom;
        default: m = '1;
      endcase
      run_row(m, 2, r[0], $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
